// File: rtl/alu_share_arbiter_pkg.sv
// Shared opcode encodings, arbiter FSM states and the legal-opcode check
// for the ALU sharing arbiter.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ADD_ALU = 4'h0;
    localparam logic [3:0] SUB_ALU = 4'h1;
    localparam logic [3:0] AND_ALU = 4'h2;
    localparam logic [3:0] OR_ALU  = 4'h3;
    localparam logic [3:0] SLL_ALU = 4'h4;
    localparam logic [3:0] SRA_ALU = 4'h5;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {ADD_ALU, SUB_ALU, AND_ALU, OR_ALU, SLL_ALU, SRA_ALU};
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared between the two requesters. Shifts use only
// b[4:0]; add/sub wrap with no carry out.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              rst_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        if (!rst_i) begin
            case (op_i)
                ADD_ALU: result_o = a_i + b_i;
                SUB_ALU: result_o = a_i - b_i;
                AND_ALU: result_o = a_i & b_i;
                OR_ALU:  result_o = a_i | b_i;
                SLL_ALU: result_o = a_i << b_i[4:0];
                SRA_ALU: result_o = $signed(a_i) >>> b_i[4:0];
                default: result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one ALU: grant, register operands,
// evaluate for one cycle, then hold the result until the owner takes it.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic              busy,
    output arb_state_t        dbg_state_o
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic              grant;
    logic              rsp_hs;
    logic [DATA_W-1:0] alu_result;

    // Valid/ready: a transfer happens on a rising edge where both valid and
    // ready are high. Request ready only follows its own valid in IDLE, and
    // response valid is held with stable data until the owner's ready.
    always_comb begin
        grant = 1'b0;
        if (ARB_MODE == 1)
            grant = !req0_valid;
        else if (req0_valid && req1_valid)
            grant = !last_grant_q;
        else
            grant = !req0_valid;
    end

    assign req0_ready = reset_n && (state_q == ARB_IDLE) && req0_valid && !grant;
    assign req1_ready = reset_n && (state_q == ARB_IDLE) && req1_valid &&  grant;
    assign rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;

    alu_share_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
        .rst_i    (1'b0),
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (req0_ready || req1_ready) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    op_d         = grant ? req1_op : req0_op;
                    a_d          = grant ? req1_a  : req0_a;
                    b_d          = grant ? req1_b  : req0_b;
                    state_d      = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                // Illegal opcodes never expose the ALU output.
                if (is_legal_op(op_q)) begin
                    result_d = alu_result;
                    err_d    = 1'b0;
                end else begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_hs)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    assign rsp0_valid  = (state_q == ARB_RESP) && !owner_q;
    assign rsp1_valid  = (state_q == ARB_RESP) &&  owner_q;
    assign rsp0_data   = rsp0_valid ? result_q : '0;
    assign rsp1_data   = rsp1_valid ? result_q : '0;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;
    assign busy        = (state_q != ARB_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of arbitration and ALU results.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
    logic [31:0] rsp0_data, rsp1_data;
    arb_state_t  dbg_state;

    logic        f_req0_valid = 0, f_req1_valid = 0, f_rsp0_ready = 1, f_rsp1_ready = 1;
    logic [3:0]  f_req0_op = 0, f_req1_op = 0;
    logic [31:0] f_req0_a = 0, f_req0_b = 0, f_req1_a = 0, f_req1_b = 0;
    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp0_err, f_rsp1_err, f_busy;
    logic [31:0] f_rsp0_data, f_rsp1_data;
    arb_state_t  f_dbg_state;

    alu_share_arbiter #(.ARB_MODE(0), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    alu_share_arbiter #(.ARB_MODE(1), .DATA_W(32)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op(f_req0_op),
        .req0_a(f_req0_a), .req0_b(f_req0_b),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp0_data(f_rsp0_data), .rsp0_err(f_rsp0_err),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_op(f_req1_op),
        .req1_a(f_req1_a), .req1_b(f_req1_b),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready), .rsp1_data(f_rsp1_data), .rsp1_err(f_rsp1_err),
        .busy(f_busy), .dbg_state_o(f_dbg_state)
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t pend[2];
    int   last_w = 1;
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference: {err, data} from the opcode rules with plain arithmetic.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        logic [31:0] r;
        s = b % 32;
        case (op)
            ADD_ALU: r = a + b;
            SUB_ALU: r = a - b;
            AND_ALU: r = a & b;
            OR_ALU:  r = a | b;
            SLL_ALU: r = a << s;
            SRA_ALU: r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic int arbitrate();
        if (pend[0].v && pend[1].v) return (last_w == 1) ? 0 : 1;
        return pend[0].v ? 0 : 1;
    endfunction

    task automatic drive(input int n);
        if (n == 0) begin
            req0_valid = pend[0].v; req0_op = pend[0].op; req0_a = pend[0].a; req0_b = pend[0].b;
        end else begin
            req1_valid = pend[1].v; req1_op = pend[1].op; req1_a = pend[1].a; req1_b = pend[1].b;
        end
    endtask

    task automatic new_req(input int n);
        logic [3:0] op;
        op = 4'($urandom_range(0, 7));
        if (op > 4'd5) op = 4'($urandom_range(6, 15));
        pend[n].v  = 1'b1;
        pend[n].op = op;
        pend[n].a  = $urandom;
        pend[n].b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
        drive(n);
    endtask

    // Called in the low half of the clock with requests already driven.
    task automatic serve(input int w, input int dly);
        int          lat;
        logic [32:0] exp;
        logic [1:0]  wbit, rdy_exp;
        exp  = model(pend[w].op, pend[w].a, pend[w].b);
        wbit = (w == 0) ? 2'b01 : 2'b10;
        lat  = 0;
        #1;
        while (!(req0_ready || req1_ready) && lat < 8) begin
            @(negedge clk); #1; lat++;
        end
        n_tests++;
        if ({req1_ready, req0_ready} !== wbit) begin
            n_fail++;
            $display("FAIL grant: ready=%b expected=%b", {req1_ready, req0_ready}, wbit);
        end
        @(negedge clk);
        pend[w].v  = 1'b0;
        pend[w].op = 4'($urandom);
        pend[w].a  = $urandom;
        pend[w].b  = $urandom;
        drive(w);
        #1;
        n_tests++;
        if ({busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== 5'b10000) begin
            n_fail++;
            $display("FAIL exec_cycle: busy/rsp_v/rdy=%b expected=10000",
                     {busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready});
        end
        @(negedge clk); #1;
        for (int d = 0; d <= dly; d++) begin
            n_tests++;
            if ({rsp1_valid, rsp0_valid} !== wbit
                || (w == 0 ? rsp0_data : rsp1_data) !== exp[31:0]
                || (w == 0 ? rsp0_err : rsp1_err) !== exp[32]
                || (w == 0 ? rsp1_data : rsp0_data) !== 32'h0
                || (w == 0 ? rsp1_err : rsp0_err) !== 1'b0
                || {req1_ready, req0_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL resp%0d cyc%0d: v=%b data=%h err=%b expected v=%b data=%h err=%b",
                         w, d, {rsp1_valid, rsp0_valid}, (w == 0 ? rsp0_data : rsp1_data),
                         (w == 0 ? rsp0_err : rsp1_err), wbit, exp[31:0], exp[32]);
            end
            if (d < dly) begin @(negedge clk); #1; end
        end
        if (w == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        rdy_exp = pend[1-w].v ? ~wbit : 2'b00;
        n_tests++;
        if ({busy, rsp1_valid, rsp0_valid} !== 3'b000 || {req1_ready, req0_ready} !== rdy_exp) begin
            n_fail++;
            $display("FAIL release: busy/rsp_v=%b rdy=%b expected 000 rdy=%b",
                     {busy, rsp1_valid, rsp0_valid}, {req1_ready, req0_ready}, rdy_exp);
        end
        last_w = w;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy,
             rsp0_data, rsp1_data, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs not all zero (busy=%b state=%0d)", busy, dbg_state);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        last_w = 1;
        pend[0].v = 0; pend[1].v = 0;
    endtask

    task automatic test_contention();
        pend[0] = '{1'b1, SUB_ALU, 32'd10, 32'd3};
        pend[1] = '{1'b1, SRA_ALU, 32'h8000_0000, 32'd4};
        drive(0); drive(1);
        serve(0, 0);
        serve(1, 0);
        pend[0] = '{1'b1, SUB_ALU, 32'd10, 32'd3};
        pend[1] = '{1'b1, SRA_ALU, 32'h8000_0000, 32'd4};
        drive(0); drive(1);
        serve(0, 0);
        serve(1, 1);
    endtask

    task automatic test_single_add();
        pend[0] = '{1'b1, ADD_ALU, 32'd5, 32'd7};
        drive(0);
        serve(0, 0);
    endtask

    task automatic test_illegal();
        pend[0] = '{1'b1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0};
        drive(0);
        serve(0, 0);
    endtask

    task automatic test_sll_wrap();
        pend[1] = '{1'b1, SLL_ALU, 32'd1, 32'd33};
        drive(1);
        serve(1, 0);
    endtask

    task automatic test_backpressure();
        pend[0] = '{1'b1, OR_ALU, 32'hF0F0_0000, 32'h0000_0F0F};
        pend[1] = '{1'b1, AND_ALU, 32'hFFFF_0000, 32'h1234_5678};
        drive(0); drive(1);
        serve(0, 4);
        serve(1, 0);
    endtask

    task automatic test_fixed_priority();
        int lat;
        f_req0_valid = 1; f_req0_op = SUB_ALU; f_req0_a = 32'd10; f_req0_b = 32'd3;
        f_req1_valid = 1; f_req1_op = SRA_ALU; f_req1_a = 32'h8000_0000; f_req1_b = 32'd4;
        for (int r = 0; r < 2; r++) begin
            lat = 0; #1;
            while (!(f_req0_ready || f_req1_ready) && lat < 8) begin @(negedge clk); #1; lat++; end
            n_tests++;
            if ({f_req1_ready, f_req0_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL fp_grant%0d: ready=%b expected=01", r, {f_req1_ready, f_req0_ready});
            end
            lat = 0; @(negedge clk); #1;
            while (!f_rsp0_valid && lat < 8) begin @(negedge clk); #1; lat++; end
            n_tests++;
            if (f_rsp0_valid !== 1'b1 || f_rsp0_data !== 32'd7 || f_rsp1_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fp_rsp0_%0d: v=%b data=%h expected v=1 data=00000007", r, f_rsp0_valid, f_rsp0_data);
            end
            if (r == 1) f_req0_valid = 0;
        end
        lat = 0; #1;
        while (!(f_req0_ready || f_req1_ready) && lat < 8) begin @(negedge clk); #1; lat++; end
        n_tests++;
        if ({f_req1_ready, f_req0_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fp_grant1: ready=%b expected=10", {f_req1_ready, f_req0_ready});
        end
        lat = 0; @(negedge clk); #1;
        while (!f_rsp1_valid && lat < 8) begin @(negedge clk); #1; lat++; end
        n_tests++;
        if (f_rsp1_valid !== 1'b1 || f_rsp1_data !== 32'hF800_0000 || f_rsp1_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_rsp1: v=%b data=%h expected v=1 data=f8000000", f_rsp1_valid, f_rsp1_data);
        end
        f_req1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int w;
        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n].v && $urandom_range(0, 1) == 1) new_req(n);
            if (!pend[0].v && !pend[1].v) new_req(int'($urandom_range(0, 1)));
            w = arbitrate();
            serve(w, int'($urandom_range(0, 3)));
        end
        while (pend[0].v || pend[1].v) serve(arbitrate(), 0);
    endtask

    task automatic test_reset_mid_exec();
        int lat;
        pend[0] = '{1'b1, ADD_ALU, 32'd3, 32'd4};
        drive(0);
        lat = 0; #1;
        while (!req0_ready && lat < 8) begin @(negedge clk); #1; lat++; end
        @(negedge clk);
        pend[0].v = 0; drive(0);
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy,
             rsp0_data, rsp1_data, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs not all zero (busy=%b state=%0d)", busy, dbg_state);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_w = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            n_tests++;
            if ({busy, rsp1_valid, rsp0_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL stale_rsp%0d: busy/rsp_v=%b expected=000", c, {busy, rsp1_valid, rsp0_valid});
            end
        end
        pend[0] = '{1'b1, ADD_ALU, 32'd1, 32'd1};
        drive(0);
        serve(0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pend[0] = '{1'b0, 4'h0, 32'h0, 32'h0};
        pend[1] = '{1'b0, 4'h0, 32'h0, 32'h0};
        test_reset();
        test_contention();
        test_single_add();
        test_illegal();
        test_sll_wrap();
        test_backpressure();
        test_fixed_priority();
        test_random();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
